// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, runs the MOV/MOC read handshake, loads the IR
// and hands each instruction to decode via a valid/ack pair; handles redirects and timeouts.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        halt_i,
  input  logic        moc_i,
  input  logic [31:0] mem_data_i,
  input  logic        decode_ack_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] mar_addr_o,
  output logic        mov_o,
  output logic        rw_o,
  output logic        ir_ld_o,
  output logic [31:0] ir_in_o,
  output logic        instr_valid_o,
  output logic [31:0] fetch_pc_o,
  output logic        bus_err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitMoc,
    StLoadIr,
    StDecWait,
    StError
  } state_e;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};
  localparam logic [7:0]  TimeoutLast    = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] mar_q;
  logic [31:0] ir_in_q;
  logic [31:0] fetch_pc_q;
  logic [7:0]  cnt_q;
  logic        mov_q;
  logic        rw_q;
  logic        ir_ld_q;
  logic        instr_valid_q;
  logic        bus_err_q;
  logic        redir_pend_q;
  logic [31:0] redir_tgt;

  assign redir_tgt = {redirect_pc_i[31:2], 2'b00};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      pc_q          <= ResetPcAligned;
      mar_q         <= '0;
      ir_in_q       <= '0;
      fetch_pc_q    <= '0;
      cnt_q         <= '0;
      mov_q         <= 1'b0;
      rw_q          <= 1'b1;
      ir_ld_q       <= 1'b0;
      instr_valid_q <= 1'b0;
      bus_err_q     <= 1'b0;
      redir_pend_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (redirect_i) pc_q <= redir_tgt;
          if (start_i) state_q <= StIssue;
        end
        StIssue: begin
          mar_q   <= pc_q;
          mov_q   <= 1'b1;
          cnt_q   <= '0;
          state_q <= StWaitMoc;
          // The read goes out to the old PC, so mark it stale and refetch from the target.
          if (redirect_i) begin
            pc_q         <= redir_tgt;
            redir_pend_q <= 1'b1;
          end
        end
        StWaitMoc: begin
          cnt_q <= cnt_q + 8'd1;
          if (moc_i) begin
            mov_q <= 1'b0;
            if (redir_pend_q || redirect_i) begin
              if (redirect_i) pc_q <= redir_tgt;
              redir_pend_q <= 1'b0;
              state_q      <= StIssue;
            end else begin
              ir_in_q    <= mem_data_i;
              fetch_pc_q <= pc_q;
              ir_ld_q    <= 1'b1;
              state_q    <= StLoadIr;
            end
          end else if (cnt_q == TimeoutLast) begin
            mov_q     <= 1'b0;
            bus_err_q <= 1'b1;
            state_q   <= StError;
          end else if (redirect_i) begin
            pc_q         <= redir_tgt;
            redir_pend_q <= 1'b1;
          end
        end
        StLoadIr: begin
          ir_ld_q       <= 1'b0;
          instr_valid_q <= 1'b1;
          pc_q          <= redirect_i ? redir_tgt : pc_q + 32'd4;
          state_q       <= StDecWait;
        end
        StDecWait: begin
          if (redirect_i) pc_q <= redir_tgt;
          if (decode_ack_i) begin
            instr_valid_q <= 1'b0;
            state_q       <= halt_i ? StIdle : StIssue;
          end
        end
        StError: begin
          mov_q     <= 1'b0;
          bus_err_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign mar_addr_o    = mar_q;
  assign mov_o         = mov_q;
  assign rw_o          = rw_q;
  assign ir_ld_o       = ir_ld_q;
  assign ir_in_o       = ir_in_q;
  assign instr_valid_o = instr_valid_q;
  assign fetch_pc_o    = fetch_pc_q;
  assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: normal fetches, timeout, redirect, PC wrap, halt and
// reset mid-transfer. A second instance starts at 32'hFFFF_FFFC to exercise the wrap.
module tb_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        start_i = 1'b0;
  logic        halt_i = 1'b0;
  logic        moc_i = 1'b0;
  logic [31:0] mem_data_i = '0;
  logic        decode_ack_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;

  logic [31:0] mar_addr_o, ir_in_o, fetch_pc_o;
  logic        mov_o, rw_o, ir_ld_o, instr_valid_o, bus_err_o;
  logic [31:0] d1_mar, d1_ir_in, d1_fetch_pc;
  logic        d1_mov, d1_rw, d1_ir_ld, d1_valid, d1_bus_err;

  int n_checks = 0;
  int n_errors = 0;
  int ld_cnt = 0;
  int ld_base;

  always #5 clk_i = ~clk_i;

  fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .halt_i(halt_i), .moc_i(moc_i),
    .mem_data_i(mem_data_i), .decode_ack_i(decode_ack_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .mar_addr_o(mar_addr_o), .mov_o(mov_o), .rw_o(rw_o),
    .ir_ld_o(ir_ld_o), .ir_in_o(ir_in_o), .instr_valid_o(instr_valid_o),
    .fetch_pc_o(fetch_pc_o), .bus_err_o(bus_err_o)
  );

  fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT(16)) dut_wrap (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .halt_i(halt_i), .moc_i(moc_i),
    .mem_data_i(mem_data_i), .decode_ack_i(decode_ack_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .mar_addr_o(d1_mar), .mov_o(d1_mov), .rw_o(d1_rw),
    .ir_ld_o(d1_ir_ld), .ir_in_o(d1_ir_in), .instr_valid_o(d1_valid),
    .fetch_pc_o(d1_fetch_pc), .bus_err_o(d1_bus_err)
  );

  // Count IR load pulses of the main instance.
  always @(posedge ir_ld_o) ld_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  task automatic kick();
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_mov(input string tag);
    int n = 0;
    while (mov_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check_eq(tag, 32'(mov_o), 32'd1);
  endtask

  // Waits for the read, checks its address, answers after 'delay' cycles and checks the load.
  task automatic do_fetch(input string tag, input logic [31:0] exp_mar, input logic [31:0] data,
                          input int delay);
    wait_mov({tag, "_mov"});
    check_eq({tag, "_mar"}, mar_addr_o, exp_mar);
    ld_base = ld_cnt;
    repeat (delay) @(negedge clk_i);
    moc_i = 1'b1;
    mem_data_i = data;
    @(negedge clk_i);
    moc_i = 1'b0;
    check_eq({tag, "_irld"}, 32'(ir_ld_o), 32'd1);
    check_eq({tag, "_irin"}, ir_in_o, data);
    check_eq({tag, "_fpc"}, fetch_pc_o, exp_mar);
    check_eq({tag, "_movlow"}, 32'(mov_o), 32'd0);
    @(negedge clk_i);
    check_eq({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
    check_eq({tag, "_ldcnt"}, 32'(ld_cnt), 32'(ld_base + 1));
  endtask

  task automatic do_ack(input logic h);
    decode_ack_i = 1'b1;
    halt_i = h;
    @(negedge clk_i);
    decode_ack_i = 1'b0;
    halt_i = 1'b0;
    check_eq("ack_valid_clr", 32'(instr_valid_o), 32'd0);
  endtask

  initial begin
    @(negedge clk_i);
    do_reset();
    check_eq("rst_mov", 32'(mov_o), 32'd0);
    check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
    check_eq("rst_irld", 32'(ir_ld_o), 32'd0);
    check_eq("rst_buserr", 32'(bus_err_o), 32'd0);
    check_eq("rst_rw", 32'(rw_o), 32'd1);
    check_eq("rst_mar", mar_addr_o, 32'h0);
    check_eq("rst_irin", ir_in_o, 32'h0);
    check_eq("rst_fpc", fetch_pc_o, 32'h0);

    // Basic fetch then sequential fetches.
    kick();
    do_fetch("f0", 32'h0, 32'hA5A5_0001, 0);
    do_ack(1'b0);
    do_fetch("f1", 32'h4, 32'h1111_0004, 1);
    do_ack(1'b0);
    do_fetch("f2", 32'h8, 32'h2222_0008, 0);
    do_ack(1'b0);
    do_fetch("f3", 32'hC, 32'h3333_000C, 3);
    do_ack(1'b0);

    // Timeout: MOC never arrives.
    wait_mov("to_mov");
    ld_base = ld_cnt;
    repeat (15) @(negedge clk_i);
    check_eq("to_mov_at15", 32'(mov_o), 32'd1);
    check_eq("to_err_at15", 32'(bus_err_o), 32'd0);
    @(negedge clk_i);
    check_eq("to_mov_at16", 32'(mov_o), 32'd0);
    check_eq("to_err_at16", 32'(bus_err_o), 32'd1);
    moc_i = 1'b1;
    start_i = 1'b1;
    @(negedge clk_i);
    moc_i = 1'b0;
    start_i = 1'b0;
    repeat (4) @(negedge clk_i);
    check_eq("err_sticky", 32'(bus_err_o), 32'd1);
    check_eq("err_mov", 32'(mov_o), 32'd0);
    check_eq("err_noload", 32'(ld_cnt), 32'(ld_base));
    do_reset();
    check_eq("err_rst_clr", 32'(bus_err_o), 32'd0);
    repeat (3) @(negedge clk_i);
    check_eq("err_rst_idle", 32'(mov_o), 32'd0);

    // Redirect during WAIT_MOC: the stale word is dropped.
    kick();
    wait_mov("rd_mov");
    check_eq("rd_mar0", mar_addr_o, 32'h0);
    ld_base = ld_cnt;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h0000_0103;
    @(negedge clk_i);
    redirect_i = 1'b0;
    check_eq("rd_mov_hold", 32'(mov_o), 32'd1);
    moc_i = 1'b1;
    mem_data_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    moc_i = 1'b0;
    check_eq("rd_drop_irld", 32'(ir_ld_o), 32'd0);
    check_eq("rd_drop_mov", 32'(mov_o), 32'd0);
    check_eq("rd_drop_cnt", 32'(ld_cnt), 32'(ld_base));
    do_fetch("rd_f", 32'h0000_0100, 32'h0BAD_F00D, 0);
    do_ack(1'b0);

    // PC wrap on the second instance, then halt.
    do_reset();
    kick();
    wait_mov("wr_mov");
    check_eq("wr_mar0", d1_mar, 32'hFFFF_FFFC);
    do_fetch("wr_f0", 32'h0, 32'h4444_0000, 0);
    check_eq("wr_fpc0", d1_fetch_pc, 32'hFFFF_FFFC);
    do_ack(1'b0);
    wait_mov("wr_mov1");
    check_eq("wr_mar1", d1_mar, 32'h0);
    do_fetch("wr_f1", 32'h4, 32'h5555_0004, 0);
    do_ack(1'b1);
    repeat (5) @(negedge clk_i);
    check_eq("halt_mov", 32'(mov_o), 32'd0);
    check_eq("halt_mov_d1", 32'(d1_mov), 32'd0);
    kick();
    wait_mov("halt_restart");
    check_eq("halt_mar", mar_addr_o, 32'h8);
    check_eq("halt_mar_d1", d1_mar, 32'h4);

    // Reset while a read is outstanding; a late MOC must be ignored.
    ld_base = ld_cnt;
    reset_i = 1'b1;
    @(negedge clk_i);
    reset_i = 1'b0;
    check_eq("mr_mov", 32'(mov_o), 32'd0);
    check_eq("mr_valid", 32'(instr_valid_o), 32'd0);
    moc_i = 1'b1;
    mem_data_i = 32'hFFFF_0000;
    @(negedge clk_i);
    moc_i = 1'b0;
    @(negedge clk_i);
    check_eq("mr_noload", 32'(ld_cnt), 32'(ld_base));
    check_eq("mr_idle", 32'(mov_o), 32'd0);
    kick();
    wait_mov("mr_restart");
    check_eq("mr_pc", mar_addr_o, 32'h0);
    check_eq("mr_pc_d1", d1_mar, 32'hFFFF_FFFC);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
